// File: rtl/spi_cmd_pkg.sv
// Shared types and opcodes for the SPI command/response engine.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        WDATA = 2'd2
    } state_t;

    localparam logic [7:0] CMD_LEGACY       = 8'hFF;
    localparam logic [1:0] CMD_READ_MSK     = 2'b10;
    localparam logic [7:0] CMD_WRITE        = 8'h40;
    localparam logic [7:0] CMD_NOP          = 8'h00;
    localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_cmd_responder_if.sv
// Byte-level link between SPI_Slave and the command responder.
// Handshake: i_RX_DV and o_TX_DV are single-cycle strobes; the byte beside each
// strobe is valid only in that cycle, no back-pressure, i_CS_n high aborts.
interface spi_cmd_responder_if;
    logic       i_CS_n;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;

    modport slave (
        input  i_CS_n,
        input  i_RX_DV,
        input  i_RX_Byte,
        output o_TX_DV,
        output o_TX_Byte
    );

    modport master (
        output i_CS_n,
        output i_RX_DV,
        output i_RX_Byte,
        input  o_TX_DV,
        input  o_TX_Byte
    );
endinterface

// File: rtl/spi_byte_serializer.sv
// Snapshot / shift register plus byte counter, shared by the read (byte out,
// MSB first) and write (byte in, MSB first) paths of the responder.
module spi_byte_serializer #(
    parameter int DATA_W = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Clear,
    input  logic              i_Load,
    input  logic [DATA_W-1:0] i_Load_Data,
    input  logic              i_Advance,
    input  logic              i_Shift,
    input  logic [7:0]        i_Shift_Byte,
    output logic              o_Last,
    output logic [7:0]        o_Cur_Byte,
    output logic [DATA_W-1:0] o_Shift_Next
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [DATA_W-1:0] sreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_step;

    assign o_Last       = (cnt_q == CNT_W'(NBYTES - 1));
    assign cnt_step     = o_Last ? '0 : cnt_q + 1'b1;
    assign o_Shift_Next = (sreg_q << 8) | DATA_W'(i_Shift_Byte);

    // Byte index counts from the MSB end.
    always_comb begin
        o_Cur_Byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CNT_W'(i)) o_Cur_Byte = sreg_q[(NBYTES-1-i)*8 +: 8];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (i_Clear) begin
            cnt_q <= '0;
        end else if (i_Load) begin
            // Byte 0 leaves immediately with the load, so the count starts at 1.
            sreg_q <= i_Load_Data;
            cnt_q  <= (NBYTES > 1) ? CNT_W'(1) : '0;
        end else if (i_Advance) begin
            cnt_q <= cnt_step;
        end else if (i_Shift) begin
            sreg_q <= o_Shift_Next;
            cnt_q  <= cnt_step;
        end
    end

endmodule

// File: rtl/spi_cmd_responder.sv
// Command decoder and response FSM sitting between SPI_Slave and the application:
// channel reads, control-register writes and the legacy 8'hFF state query.
module spi_cmd_responder
    import spi_cmd_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                NUM_CH     = 4,
    parameter logic [7:0]        ERR_BYTE   = DEFAULT_ERR_BYTE,
    parameter logic [DATA_W-1:0] CTRL_RESET = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    spi_cmd_responder_if.slave       spi,
    input  logic [NUM_CH*DATA_W-1:0] i_Status,
    output logic [DATA_W-1:0]        o_Ctrl,
    output logic                     o_Ctrl_Valid,
    output logic                     o_Cmd_Err,
    output state_t                   o_State
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CH_W   = clog2_min1(NUM_CH);

    state_t            state_q, state_d;
    logic              tx_dv_d, ctrl_valid_d, cmd_err_d;
    logic [7:0]        tx_byte_d;
    logic [DATA_W-1:0] ctrl_d;

    logic              ser_clear, ser_load, ser_advance, ser_shift;
    logic              ser_last;
    logic [7:0]        ser_cur_byte;
    logic [DATA_W-1:0] ser_shift_next;

    logic              is_legacy, is_read, read_ok, is_write, is_nop;
    logic [CH_W-1:0]   ch_idx;
    logic [DATA_W-1:0] sel_status;

    assign is_legacy = (spi.i_RX_Byte == CMD_LEGACY);
    assign is_read   = (spi.i_RX_Byte[7:6] == CMD_READ_MSK);
    assign read_ok   = is_read && (int'(spi.i_RX_Byte[5:0]) < NUM_CH);
    assign is_write  = (spi.i_RX_Byte == CMD_WRITE);
    assign is_nop    = (spi.i_RX_Byte == CMD_NOP);
    assign ch_idx    = spi.i_RX_Byte[CH_W-1:0];

    always_comb begin
        sel_status = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == CH_W'(k)) sel_status = i_Status[k*DATA_W +: DATA_W];
        end
    end

    spi_byte_serializer #(.DATA_W(DATA_W)) u_ser (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Clear      (ser_clear),
        .i_Load       (ser_load),
        .i_Load_Data  (sel_status),
        .i_Advance    (ser_advance),
        .i_Shift      (ser_shift),
        .i_Shift_Byte (spi.i_RX_Byte),
        .o_Last       (ser_last),
        .o_Cur_Byte   (ser_cur_byte),
        .o_Shift_Next (ser_shift_next)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Chip-select abort outranks any byte arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        if (spi.i_CS_n) begin
            state_d = IDLE;
        end else if (spi.i_RX_DV) begin
            case (state_q)
                IDLE: begin
                    if (read_ok && !is_legacy) state_d = (NBYTES > 1) ? RESP : IDLE;
                    else if (is_write)         state_d = WDATA;
                end
                RESP:    if (ser_last) state_d = IDLE;
                WDATA:   if (ser_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_dv_d      = 1'b0;
        tx_byte_d    = spi.o_TX_Byte;
        ctrl_d       = o_Ctrl;
        ctrl_valid_d = 1'b0;
        cmd_err_d    = 1'b0;
        ser_clear    = 1'b0;
        ser_load     = 1'b0;
        ser_advance  = 1'b0;
        ser_shift    = 1'b0;
        if (spi.i_CS_n) begin
            ser_clear = 1'b1;
        end else if (spi.i_RX_DV) begin
            case (state_q)
                IDLE: begin
                    if (is_legacy) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = i_Status[7:0];
                    end else if (read_ok) begin
                        ser_load  = 1'b1;
                        tx_dv_d   = 1'b1;
                        tx_byte_d = sel_status[DATA_W-1 -: 8];
                    end else if (is_write) begin
                        ser_clear = 1'b1;
                    end else if (!is_nop) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = ERR_BYTE;
                        cmd_err_d = 1'b1;
                    end
                end
                RESP: begin
                    ser_advance = 1'b1;
                    tx_dv_d     = 1'b1;
                    tx_byte_d   = ser_cur_byte;
                end
                WDATA: begin
                    ser_shift = 1'b1;
                    if (ser_last) begin
                        ctrl_d       = ser_shift_next;
                        ctrl_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            spi.o_TX_DV   <= 1'b0;
            spi.o_TX_Byte <= '0;
            o_Ctrl        <= CTRL_RESET;
            o_Ctrl_Valid  <= 1'b0;
            o_Cmd_Err     <= 1'b0;
        end else begin
            spi.o_TX_DV   <= tx_dv_d;
            spi.o_TX_Byte <= tx_byte_d;
            o_Ctrl        <= ctrl_d;
            o_Ctrl_Valid  <= ctrl_valid_d;
            o_Cmd_Err     <= cmd_err_d;
        end
    end

    assign o_State = state_q;

endmodule
